// File: rtl/bmu_pkg.sv
// Shared types and opcode constants for the bit-manipulation unit.
// Imported by the carry-less multiply datapath and its testbench.
package bmu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } clmul_state_t;

  localparam logic [2:0] F3_CLMUL  = 3'b001;
  localparam logic [2:0] F3_CLMULR = 3'b010;
  localparam logic [2:0] F3_CLMULH = 3'b011;

endpackage

// File: rtl/clmul_step.sv
// One iteration of the carry-less multiply: XOR of A shifted by each set bit
// of a BPC-wide slice of B, positioned at bit index base.
module clmul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [BPC-1:0]           b_slice,
  input  logic [$clog2(WIDTH)-1:0] base,
  output logic [2*WIDTH-1:0]       partial
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BPC; j++) begin
      if (b_slice[j]) partial ^= {{WIDTH{1'b0}}, a} << (base + j);
    end
  end

endmodule

// File: rtl/bmu_clmul_seq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) with start/done handshake,
// retiring BPC bits of B per RUN cycle.
module bmu_clmul_seq
  import bmu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Funct3,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(WIDTH);

  clmul_state_t         state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2:0]           f3_q;
  logic [2*WIDTH-1:0]   p_q, p_next, step;
  logic [WIDTH-1:0]     prev_q;
  logic [IW-1:0]        base;
  logic [BPC-1:0]       b_slice;
  logic                 accept, last;

  function automatic logic [WIDTH-1:0] select_result(input logic [2:0] f3,
                                                     input logic [2*WIDTH-1:0] p);
    case (f3)
      F3_CLMUL:  return p[WIDTH-1:0];
      F3_CLMULH: return p[2*WIDTH-1:WIDTH];
      F3_CLMULR: return p[2*WIDTH-2:WIDTH-1];
      default:   return '0;
    endcase
  endfunction

  assign accept  = (state_q == IDLE) && Start && !Flush;
  assign last    = (count_q == CW'(N - 1));
  assign base    = IW'(count_q * BPC);
  assign b_slice = BPC'(b_q >> base);
  assign p_next  = p_q ^ step;

  clmul_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .a       (a_q),
    .b_slice (b_slice),
    .base    (base),
    .partial (step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (Flush) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE) && !Flush;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      p_q     <= '0;
      prev_q  <= '0;
      Result  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            f3_q    <= Funct3;
            p_q     <= '0;
            count_q <= '0;
          end
        end
        RUN: begin
          if (!Flush) begin
            p_q     <= p_next;
            count_q <= last ? '0 : count_q + CW'(1);
            if (last) begin
              prev_q <= Result;
              Result <= select_result(f3_q, p_next);
            end
          end
        end
        DONE: begin
          // A flush in the Done cycle withdraws the result just published.
          if (Flush) Result <= prev_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_clmul_seq.sv
// Directed testbench for bmu_clmul_seq across WIDTH/BPC configurations,
// with hand-computed carry-less products.
module tb_bmu_clmul_seq;
  import bmu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  start_v = '0;
  logic        flush = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  logic [2:0]  op_f3 = '0;

  logic [3:0]  done_v, busy_v;
  logic [31:0] r0, r1, r2;
  logic [63:0] r3;
  logic [63:0] res_v [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bmu_clmul_seq #(.WIDTH(32), .BPC(4)) dut_w32_b4 (
    .clk(clk), .reset(reset), .Start(start_v[0]), .Flush(flush),
    .A(op_a[31:0]), .B(op_b[31:0]), .Funct3(op_f3),
    .Busy(busy_v[0]), .Done(done_v[0]), .Result(r0));

  bmu_clmul_seq #(.WIDTH(32), .BPC(1)) dut_w32_b1 (
    .clk(clk), .reset(reset), .Start(start_v[1]), .Flush(flush),
    .A(op_a[31:0]), .B(op_b[31:0]), .Funct3(op_f3),
    .Busy(busy_v[1]), .Done(done_v[1]), .Result(r1));

  bmu_clmul_seq #(.WIDTH(32), .BPC(32)) dut_w32_b32 (
    .clk(clk), .reset(reset), .Start(start_v[2]), .Flush(flush),
    .A(op_a[31:0]), .B(op_b[31:0]), .Funct3(op_f3),
    .Busy(busy_v[2]), .Done(done_v[2]), .Result(r2));

  bmu_clmul_seq #(.WIDTH(64), .BPC(4)) dut_w64_b4 (
    .clk(clk), .reset(reset), .Start(start_v[3]), .Flush(flush),
    .A(op_a), .B(op_b), .Funct3(op_f3),
    .Busy(busy_v[3]), .Done(done_v[3]), .Result(r3));

  assign res_v[0] = {32'b0, r0};
  assign res_v[1] = {32'b0, r1};
  assign res_v[2] = {32'b0, r2};
  assign res_v[3] = r3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op on instance sel, watch Busy until Done, then check latency,
  // result, one-cycle Done and that a Start held during Done is ignored.
  // A nonzero poke cycle re-pulses Start with different operands mid-RUN.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f3, input int lat, input logic [63:0] exp,
                        input string tag, input int poke);
    int done_cyc = 0;
    logic busy_ok = 1'b1;
    @(negedge clk);
    op_a = a; op_b = b; op_f3 = f3; start_v[sel] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start_v[sel] = 1'b0;
      busy_ok &= busy_v[sel];
      if (done_v[sel]) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == poke) begin
        op_a = ~a; op_b = 64'h3; op_f3 = F3_CLMULH; start_v[sel] = 1'b1;
      end
    end
    check({tag, "_lat"}, 64'(done_cyc), 64'(lat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_res"}, res_v[sel], exp);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    check({tag, "_done_pulse"}, 64'(done_v[sel]), 64'd0);
    check({tag, "_idle_after"}, 64'(busy_v[sel]), 64'd0);
    check({tag, "_hold"}, res_v[sel], exp);
  endtask

  initial begin
    logic done_seen;

    #1;
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_done", 64'(done_v[0]), 64'd0);
    check("rst_res", res_v[0], 64'd0);
    check("rst_res64", res_v[3], 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(0, 64'h3, 64'h3, F3_CLMUL, 9, 64'h5, "c3x3", 0);
    run_op(0, 64'h8000_0000, 64'h8000_0000, F3_CLMUL,  9, 64'h0,         "msb_clmul", 0);
    run_op(0, 64'h8000_0000, 64'h8000_0000, F3_CLMULH, 9, 64'h4000_0000, "msb_clmulh", 0);
    run_op(0, 64'h8000_0000, 64'h8000_0000, F3_CLMULR, 9, 64'h8000_0000, "msb_clmulr", 0);

    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMUL,  9,  64'h5555_5555, "ones_b4_l", 0);
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMULH, 9,  64'h5555_5555, "ones_b4_h", 0);
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMULR, 9,  64'hAAAA_AAAA, "ones_b4_r", 0);
    run_op(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMUL,  33, 64'h5555_5555, "ones_b1_l", 0);
    run_op(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMULH, 33, 64'h5555_5555, "ones_b1_h", 0);
    run_op(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMUL,  2,  64'h5555_5555, "ones_b32_l", 0);
    run_op(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, F3_CLMULH, 2,  64'h5555_5555, "ones_b32_h", 0);

    run_op(0, 64'h1234_5678, 64'h100, F3_CLMUL,  9, 64'h3456_7800, "shift8_l", 0);
    run_op(0, 64'h1234_5678, 64'h100, F3_CLMULH, 9, 64'h12,        "shift8_h", 0);

    // Start mid-RUN with other operands must not disturb the op in flight.
    run_op(0, 64'hF, 64'h5, F3_CLMUL, 9, 64'h33, "poke", 3);

    // Flush together with a second Start in RUN cycle 4.
    @(negedge clk);
    op_a = 64'h3; op_b = 64'h3; op_f3 = F3_CLMUL; start_v[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    check("flush_pre_busy", 64'(busy_v[0]), 64'd1);
    flush = 1'b1; start_v[0] = 1'b1; op_a = 64'h7; op_b = 64'h9;
    @(negedge clk);
    flush = 1'b0; start_v[0] = 1'b0;
    check("flush_busy", 64'(busy_v[0]), 64'd0);
    check("flush_done", 64'(done_v[0]), 64'd0);
    check("flush_hold", res_v[0], 64'h33);
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      done_seen |= done_v[0] | busy_v[0];
    end
    check("flush_quiet", 64'(done_seen), 64'd0);

    run_op(0, 64'h1234_5678, 64'h100, F3_CLMULH, 9, 64'h12, "after_flush", 0);
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b000, 9, 64'h0, "illegal", 0);
    run_op(0, 64'hF, 64'h5, F3_CLMUL, 9, 64'h33, "pre_reset", 0);

    // Asynchronous reset mid-RUN, away from any clock edge.
    @(negedge clk);
    op_a = 64'h3; op_b = 64'h3; op_f3 = F3_CLMUL; start_v[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy_v[0]), 64'd0);
    check("arst_done", 64'(done_v[0]), 64'd0);
    check("arst_res", res_v[0], 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_idle", 64'(busy_v[0]), 64'd0);
    run_op(0, 64'h3, 64'h3, F3_CLMUL, 9, 64'h5, "post_reset", 0);

    run_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F3_CLMULH, 17,
           64'h5555_5555_5555_5555, "w64_h", 0);
    run_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F3_CLMUL, 17,
           64'h5555_5555_5555_5555, "w64_l", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
